// File: rtl/demux_rr_dispatch_if.sv
// Word handshake into the dispatcher and the registered i/sel/o_valid drive toward the demux.
interface demux_rr_dispatch_if #(
    parameter int width = 8,
    parameter int snum  = 3
);
    logic [width-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] i;
    logic [snum-1:0]  sel;
    logic             o_valid;

    modport master (
        output in_data, in_valid,
        input  in_ready, i, sel, o_valid
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, i, sel, o_valid
    );
endinterface

// File: rtl/demux_rr_dispatch.sv
// FIFO-buffered round-robin feeder for the 1-to-2**snum demux; registered i/sel/o_valid.
// Optional dispatch counter port disp_cnt is enabled by DEMUX_RR_DISPATCH_CNT_EN.
module demux_rr_dispatch #(
    parameter int width = 8,
    parameter int snum  = 3,
    parameter int dlog  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_rr_dispatch_if.slave   bus,
    input  logic [2**snum-1:0]   ch_en,
    output logic [dlog:0]        fifo_cnt
`ifdef DEMUX_RR_DISPATCH_CNT_EN
    ,
    output logic [15:0]          disp_cnt
`endif
);
    localparam int nch   = 2**snum;
    localparam int depth = 2**dlog;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t           state, state_nxt;
    logic [width-1:0] mem [depth];
    logic [dlog-1:0]  wr_ptr, rd_ptr;
    logic [snum-1:0]  last_sel, rr_sel, cand;
    logic             rr_found;
    logic             full, push, pop;
    logic [dlog:0]    cnt_nxt;

    // in_ready is held low while reset is asserted, then tracks the registered count.
    assign full         = (fifo_cnt == (dlog+1)'(depth));
    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready;

    // Next enabled channel strictly after last_sel; last_sel itself is the final candidate.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        rr_sel   = last_sel;
        rr_found = 1'b0;
        cand     = last_sel;
        for (int k = 1; k <= nch; k++) begin
            cand = last_sel + snum'(k);
            if (!rr_found && ch_en[cand]) begin
                rr_sel   = cand;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments so all flops update together.
            state <= state_nxt;
        end
    end

    // State is non-IDLE exactly when the FIFO holds a word, so it qualifies the pop.
    always_comb begin
        pop       = 1'b0;
        cnt_nxt   = fifo_cnt;
        state_nxt = state;
        if (state != IDLE && ch_en != '0)
            pop = 1'b1;
        if (push && !pop)
            cnt_nxt = fifo_cnt + (dlog+1)'(1);
        else if (pop && !push)
            cnt_nxt = fifo_cnt - (dlog+1)'(1);
        if (cnt_nxt == '0)
            state_nxt = IDLE;
        else if (ch_en != '0)
            state_nxt = RUN;
        else
            state_nxt = STALL;
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            last_sel    <= '1;
            bus.i       <= '0;
            bus.sel     <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            fifo_cnt <= cnt_nxt;
            if (push)
                wr_ptr <= wr_ptr + dlog'(1);
            if (pop) begin
                rd_ptr      <= rd_ptr + dlog'(1);
                bus.i       <= mem[rd_ptr];
                bus.sel     <= rr_sel;
                last_sel    <= rr_sel;
                bus.o_valid <= 1'b1;
            end else begin
                // Idle cycles drive i = 0 so every demux output stays low; sel holds.
                bus.i       <= '0;
                bus.o_valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX_RR_DISPATCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp_cnt <= '0;
        else if (pop && disp_cnt != 16'hFFFF)
            disp_cnt <= disp_cnt + 16'd1;
    end
`else
    // Dispatch counter not built.
`endif

endmodule
